fft_stream_reorder: RTL and testbench
=====================================

Name: fft_stream_reorder

Overview:
Parametrised streaming reorder buffer that sits on the output of the team's radix-2 FFT cores, such as the FFT32. It takes frames of N complex samples in bit-reversed order and emits them in natural order. Selectable bypass mode passes natural order through unchanged. Ping-pong double buffering sustains back-to-back frames at one sample per clock, with no backpressure.

Parameters:
LOG2N, 5, log2 of frame size; N = 2**LOG2N (range 2..10)
WIDTH, 16, bit width of each real/imag component (signed)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input sample valid; a frame is N accepted samples, gaps allowed
din_r  in  WIDTH  input real part
din_i  in  WIDTH  input imag part
bitrev_en  in  1  1 = reverse bit-reversed order, 0 = bypass; sampled with the first sample of each frame
out_valid  out  1  output sample valid
dout_r  out  WIDTH  output real part
dout_i  out  WIDTH  output imag part
out_first  out  1  high with the first output sample of a frame
out_last  out  1  high with the last output sample of a frame

Behaviour:
- Storage: two banks (A/B), N x 2*WIDTH each; registered read.
- Write side:
  - wr_idx (LOG2N bits) and wr_bank; a sample is accepted on any edge with in_valid=1.
  - Write address = bitrev(wr_idx) if the frame's latched mode is 1, else wr_idx.
  - Mode latched when wr_idx=0 is accepted.
  - At wr_idx=N-1, wr_idx wraps to 0, wr_bank toggles and a drain request is issued for the completed bank.
- Read FSM:
  - IDLE: waits for a drain request, then moves to DRAIN with rd_idx=0 and rd_bank = completed bank.
  - DRAIN: reads address rd_idx each cycle, rd_idx+1. After reading N-1, returns to IDLE, or starts the next drain immediately if a request is pending that cycle.
- Latency: last sample of a frame accepted at edge t → first output at edge t+2. N consecutive out_valid cycles follow, no gaps.
- out_first and out_last are asserted on output index 0 and N-1 respectively. When N outputs occur in the same cycle as a new frame's index 0, out_first and out_last are still driven per index.
- No overflow is possible: a frame needs at least N cycles, and a drain takes exactly N. With continuous input, write of frame k+1 and drain of frame k overlap fully, and a bank is never written while being drained. Back-to-back frames produce continuous out_valid.
- Data is bit-exact; no arithmetic, no rounding.
- Reset (rst_n=0 at an edge):
  - wr_idx=0, wr_bank=A, FSM=IDLE, pending request cleared.
  - out_valid=0, out_first=0, out_last=0, dout_r=0, dout_i=0.
- Reset mid-frame or mid-drain discards all buffered data; the first sample after reset is index 0 of a new frame. Memory contents are not cleared.
- in_valid=0 mid-frame: the write index holds; no timeout.
- dout_r and dout_i hold their last value when out_valid=0.

Optional Feature:
FFT_REORDER_SYNC_EN
- Defined:
  - Adds input in_sof (1 bit) and output sync_err (1 bit, sticky, reset 0).
  - in_valid=1 and in_sof=1 forces this sample to wr_idx=0; any partial frame is discarded, with no drain issued for it.
  - If wr_idx was not 0 at that edge, sync_err is set 1 from the next edge until reset.
  - in_sof with in_valid=0 is ignored.
- Undefined: no in_sof or sync_err ports; framing purely by counting.

Test Plan:
- N=32, bitrev_en=1, 32 contiguous samples with din_r=bitrev5(k), din_i=-k → dout_r=0..31 ascending, dout_i=-bitrev5(j), first output 2 cycles after last input, out_first at j=0, out_last at j=31.
- N=32, bitrev_en=0, din_r=k → dout_r=0..31 unchanged order; then bitrev_en toggled to 1 mid-frame → no effect until the next frame's index 0.
- Three back-to-back frames (96 continuous in_valid) → 96 continuous out_valid cycles, each frame correctly reordered, no bank corruption.
- in_valid gapped 1-on/2-off across a frame → output still 32 contiguous samples starting 2 cycles after the last accepted input.
- rst_n=0 for one cycle after 10 samples → out_valid stays 0; a next full frame of 32 is output correctly; rst_n=0 during a drain → out_valid=0 at the next edge.
- With FFT_REORDER_SYNC_EN: in_sof at sample 7 of a frame → sync_err=1, partial frame dropped, the following 32 samples output as one correct frame.

Source files
------------

// File: rtl/fft_stream_reorder_if.sv
// Sample stream bundle for fft_stream_reorder: input samples and naturally ordered output.
// With FFT_REORDER_SYNC_EN defined, the in_sof input and the sticky sync_err output are added.
interface fft_stream_reorder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] din_r;
  logic [WIDTH-1:0] din_i;
  logic             bitrev_en;
  logic             out_valid;
  logic [WIDTH-1:0] dout_r;
  logic [WIDTH-1:0] dout_i;
  logic             out_first;
  logic             out_last;
`ifdef FFT_REORDER_SYNC_EN
  logic             in_sof;
  logic             sync_err;

  modport master (output in_valid, din_r, din_i, bitrev_en, in_sof,
                  input  out_valid, dout_r, dout_i, out_first, out_last, sync_err);
  modport slave  (input  in_valid, din_r, din_i, bitrev_en, in_sof,
                  output out_valid, dout_r, dout_i, out_first, out_last, sync_err);
`else
  modport master (output in_valid, din_r, din_i, bitrev_en,
                  input  out_valid, dout_r, dout_i, out_first, out_last);
  modport slave  (input  in_valid, din_r, din_i, bitrev_en,
                  output out_valid, dout_r, dout_i, out_first, out_last);
`endif
endinterface

// File: rtl/fft_stream_reorder.sv
// Ping-pong reorder buffer: bit-reversed (or natural, in bypass) input frames out in natural order.
// Optional FFT_REORDER_SYNC_EN adds in_sof resynchronisation and a sticky sync_err flag.
module fft_stream_reorder #(
  parameter int LOG2N = 5,
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fft_stream_reorder_if.slave io
);
  localparam int N = 1 << LOG2N;

  typedef logic [LOG2N-1:0] idx_t;
  typedef enum logic {IDLE, DRAIN} state_t;

  localparam idx_t LAST = idx_t'(N - 1);

  function automatic idx_t bitrev(input idx_t v);
    idx_t r;
    for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
    return r;
  endfunction

  // Bank select is the address MSB: {bank, index}.
  logic [2*WIDTH-1:0] mem [2*N];

  idx_t   wr_idx;
  logic   wr_bank;
  logic   mode_q;
  logic   req_pend;
  logic   req_bank;
  state_t state;
  idx_t   rd_idx;
  logic   rd_bank;

  logic   sof;
  idx_t   eff_idx;
  logic   cur_mode;
  idx_t   wr_addr;
  logic   wr_wrap;
  logic   req_take;

`ifdef FFT_REORDER_SYNC_EN
  assign sof = io.in_valid & io.in_sof;
`else
  assign sof = 1'b0;
`endif

  // A start-of-frame marker restarts the current bank; the partial frame is simply overwritten.
  assign eff_idx  = sof ? '0 : wr_idx;
  assign cur_mode = (eff_idx == '0) ? io.bitrev_en : mode_q;
  assign wr_addr  = cur_mode ? bitrev(eff_idx) : eff_idx;
  assign wr_wrap  = io.in_valid && (eff_idx == LAST);
  assign req_take = req_pend && ((state == IDLE) || (rd_idx == LAST));

  always_ff @(posedge clk) begin
    if (rst_n && io.in_valid) mem[{wr_bank, wr_addr}] <= {io.din_r, io.din_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      mode_q   <= 1'b0;
      req_pend <= 1'b0;
      req_bank <= 1'b0;
`ifdef FFT_REORDER_SYNC_EN
      io.sync_err <= 1'b0;
`endif
    end else begin
      if (io.in_valid) begin
        if (eff_idx == '0) mode_q <= io.bitrev_en;
        if (wr_wrap) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= eff_idx + 1'b1;
        end
      end
      // A new request can never coincide with an unconsumed one: frames take >= N cycles.
      if (req_take) req_pend <= 1'b0;
      if (wr_wrap) begin
        req_pend <= 1'b1;
        req_bank <= wr_bank;
      end
`ifdef FFT_REORDER_SYNC_EN
      if (sof && (wr_idx != '0)) io.sync_err <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_idx       <= '0;
      rd_bank      <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_first <= 1'b0;
      io.out_last  <= 1'b0;
      io.dout_r    <= '0;
      io.dout_i    <= '0;
    end else begin
      io.out_valid <= 1'b0;
      io.out_first <= 1'b0;
      io.out_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_pend) begin
            state   <= DRAIN;
            rd_idx  <= '0;
            rd_bank <= req_bank;
          end
        end
        DRAIN: begin
          {io.dout_r, io.dout_i} <= mem[{rd_bank, rd_idx}];
          io.out_valid <= 1'b1;
          io.out_first <= (rd_idx == '0);
          io.out_last  <= (rd_idx == LAST);
          rd_idx       <= rd_idx + 1'b1;
          // Chain straight into the next drain so back-to-back frames stay gapless.
          if (rd_idx == LAST) begin
            if (req_pend) rd_bank <= req_bank;
            else          state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_stream_reorder.sv
// Scoreboard bench for fft_stream_reorder: per-frame expected output is queued at stimulus time.
module tb_fft_stream_reorder;
  localparam int LOG2N = 5;
  localparam int N     = 1 << LOG2N;
  localparam int W     = 16;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] i;
    bit           f;
    bit           l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   in_frame = 0;
  exp_t exp_q[$];
  int   lat_q[$];

  fft_stream_reorder_if #(.WIDTH(W)) bus ();

  fft_stream_reorder #(.LOG2N(LOG2N), .WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (v[b]) r |= 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
`ifdef FFT_REORDER_SYNC_EN
      bus.in_sof = 1'b0;
`endif
    end
  endtask

  task automatic quiet(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("quiet_ov", bus.out_valid, 0);
    end
  endtask

  // pat 0: r=bitrev(k), i=-k; pat 1: r=k, i=~k; pat 2: random
  task automatic send_frame(input bit mode, input int toggle_at, input int gap,
                            input int pat, input bit sof0);
    logic [W-1:0] r, i;
    logic [2*W-1:0] mdl [N];
    int last_e = 0;
    for (int k = 0; k < N; k++) begin
      case (pat)
        0:       begin r = W'(brev(k)); i = W'(-k); end
        1:       begin r = W'(k);       i = ~W'(k); end
        default: begin r = W'($urandom); i = W'($urandom); end
      endcase
      mdl[mode ? brev(k) : k] = {r, i};
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.din_r     = r;
      bus.din_i     = i;
      bus.bitrev_en = (k >= toggle_at) ? ~mode : mode;
`ifdef FFT_REORDER_SYNC_EN
      bus.in_sof = sof0 && (k == 0);
`endif
      last_e = cyc;
      if (k < N - 1) idle(gap);
    end
    for (int j = 0; j < N; j++)
      exp_q.push_back('{r: mdl[j][2*W-1:W], i: mdl[j][W-1:0], f: (j == 0), l: (j == N - 1)});
    lat_q.push_back(last_e + 3);
  endtask

  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.din_r     = W'($urandom);
      bus.din_i     = W'($urandom);
      bus.bitrev_en = 1'b1;
`ifdef FFT_REORDER_SYNC_EN
      bus.in_sof = 1'b0;
`endif
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    lat_q.delete();
    in_frame = 0;
    @(posedge clk); #1;
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_of", bus.out_first, 0);
    chk("rst_ol", bus.out_last, 0);
    rst_n = 1'b1;
  endtask

  // Output monitor, sampling on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexp_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dout_r", bus.dout_r, e.r);
          chk("dout_i", bus.dout_i, e.i);
          chk("first", bus.out_first, e.f);
          chk("last", bus.out_last, e.l);
          if (bus.out_first && lat_q.size() > 0) chk("latency", cyc, lat_q.pop_front());
        end
        in_frame = !bus.out_last;
      end else if (in_frame) begin
        chk("gap", bus.out_valid, 1);
        in_frame = 0;
      end
    end
  end

  initial begin
    int guard;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din_r     = '0;
    bus.din_i     = '0;
    bus.bitrev_en = 1'b0;
`ifdef FFT_REORDER_SYNC_EN
    bus.in_sof = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_of", bus.out_first, 0);
    chk("rst_ol", bus.out_last, 0);
    chk("rst_dr", bus.dout_r, 0);
    chk("rst_di", bus.dout_i, 0);
`ifdef FFT_REORDER_SYNC_EN
    chk("rst_serr", bus.sync_err, 0);
`endif
    rst_n = 1'b1;

    send_frame(1, N, 0, 0, 0);          // bit-reversed ramp
    idle(40);
    send_frame(0, 10, 0, 1, 0);         // bypass, bitrev_en flips mid-frame
    idle(40);
    send_frame(1, N, 0, 1, 0);          // next frame picks up reverse mode
    idle(40);
    send_frame(1, N, 0, 2, 0);          // three back-to-back frames
    send_frame(0, N, 0, 2, 0);
    send_frame(1, N, 0, 2, 0);
    idle(40);
    send_frame(1, N, 2, 2, 0);          // 1-on/2-off input
    idle(40);

    send_partial(10);                   // reset mid-frame
    reset_pulse();
    quiet(40);
    send_frame(1, N, 0, 2, 0);
    idle(40);

    send_frame(1, N, 0, 2, 0);          // reset mid-drain
    idle(6);
    reset_pulse();
    quiet(40);
    send_frame(0, N, 0, 2, 0);
    idle(40);

`ifdef FFT_REORDER_SYNC_EN
    chk("serr_pre", bus.sync_err, 0);
    send_partial(7);
    send_frame(1, N, 0, 2, 1);
    idle(2);
    chk("serr_set", bus.sync_err, 1);
    idle(40);
    chk("serr_hold", bus.sync_err, 1);
`endif

    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    chk("flush", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
